// File: rtl/instr_encoder_if.sv
// instr_encoder_if
//   Bundles the encoder's two streams: the decoded-field input stream
//   (valid/ready, last, class/opcode/registers/immediate) and the
//   instruction memory write port it drives.
//   master : program source side (drives fields, sees ready and writes)
//   slave  : encoder side (consumes fields, drives ready and the write port)
// Parameter: IMEM_AW - instruction memory address width.
interface instr_encoder_if #(
   parameter int IMEM_AW = 8
);
   logic               in_valid;
   logic               in_ready;
   logic               in_last;
   logic [3:0]         in_cls;
   logic [2:0]         in_op;
   logic [2:0]         in_ra;
   logic [2:0]         in_rb;
   logic [7:0]         in_imm;
   logic               wr_en;
   logic [IMEM_AW-1:0] wr_addr;
   logic [8:0]         wr_data;

   modport master (
      output in_valid, in_last, in_cls, in_op, in_ra, in_rb, in_imm,
      input  in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  in_valid, in_last, in_cls, in_op, in_ra, in_rb, in_imm,
      output in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs decoded instruction fields into 9-bit machine words and writes
//   them to instruction memory at consecutive addresses from a base.
//   Optional feature macro: ENC_RANGE_CHECK_EN (field range checking; an
//   out-of-range bundle is consumed without a write and flags an error).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begin a load at base_addr (ignored while busy)
//   base_addr   - first write address, sampled on accepted start
//   bus         - field stream in / memory write port out (slave modport)
//   busy        - high in LOAD and DONE
//   done        - one-cycle pulse in DONE, coincides with the final write
//   count       - words written in the current/last load
//   err         - sticky error for the current/last load
//   err_addr    - address associated with the first error
module instr_encoder #(
   parameter int IMEM_AW = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [IMEM_AW-1:0] base_addr,
   instr_encoder_if.slave     bus,
   output logic               busy,
   output logic               done,
   output logic [IMEM_AW:0]   count,
   output logic               err,
   output logic [IMEM_AW-1:0] err_addr
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0] cls;
      logic [2:0] op;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [7:0] imm;
      logic       last;
   } fields_t;

   // count value meaning every address of the memory has been written
   localparam logic [IMEM_AW:0] FULL_CNT = {1'b1, {IMEM_AW{1'b0}}};

   state_t             state_q, state_d;
   fields_t            f;
   logic [8:0]         enc_word;
   logic               legal;
   logic               fire;
   logic               do_write;
   logic               bad_hit;
   logic               ovf;
   logic [IMEM_AW-1:0] ptr_q;
   logic [IMEM_AW:0]   cnt_q;
   logic [IMEM_AW:0]   cnt_nxt;
   logic               err_q;
   logic [IMEM_AW-1:0] err_addr_q;
   logic               wr_en_q;
   logic [IMEM_AW-1:0] wr_addr_q;
   logic [8:0]         wr_data_q;

   assign f = '{cls:  bus.in_cls,
                op:   bus.in_op,
                ra:   bus.in_ra,
                rb:   bus.in_rb,
                imm:  bus.in_imm,
                last: bus.in_last};

   // ------------------------------------------------------------------
   // Field packing. Fields are truncated to the width each class keeps.
   // ------------------------------------------------------------------
   always_comb begin
      enc_word = 9'h1FF;
      case (f.cls)
         4'd0: enc_word = {2'b00, f.op[0], f.ra, f.rb};
         4'd1: enc_word = {2'b01, f.op, f.ra[1:0], f.rb[1:0]};
         4'd2: enc_word = {4'b1000, f.op[0], f.imm[3:0]};
         4'd3: enc_word = {4'b1001, f.op[0], f.imm[3:0]};
         4'd4: enc_word = {6'b101010, f.rb};
         4'd5: enc_word = {4'b1010, f.op[1:0], f.ra};
         4'd6: enc_word = {5'b10110, f.op[0], f.ra};
         4'd7: enc_word = {6'b101110, f.rb};
         4'd8: enc_word = {6'b101111, f.ra};
         4'd9: enc_word = {5'b11000, f.op[0], f.imm[2:0]};
         default: enc_word = 9'h1FF;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   // cls5 op=2 would alias the cls4 prefix, so it is rejected along with
   // anything that does not fit its field width.
   always_comb begin
      legal = 1'b1;
      case (f.cls)
         4'd0, 4'd6: legal = (f.op <= 3'd1);
         4'd1:       legal = (f.ra <= 3'd3) && (f.rb <= 3'd3);
         4'd2, 4'd3: legal = (f.op <= 3'd1) && (f.imm <= 8'd15);
         4'd4, 4'd7, 4'd8: legal = 1'b1;
         4'd5:       legal = (f.op == 3'd0) || (f.op == 3'd1) || (f.op == 3'd3);
         4'd9:       legal = (f.op <= 3'd1) && (f.imm <= 8'd7);
         default:    legal = 1'b0;
      endcase
   end
`else
   // Unchecked build: every bundle produces a word. The upper immediate
   // bits have no place in any encoding, so nothing consumes them here.
   logic unused_imm_hi;
   assign unused_imm_hi = ^f.imm[7:4];
   assign legal = 1'b1;
`endif

   // ------------------------------------------------------------------
   // Handshake and event decode
   // ------------------------------------------------------------------
   assign fire     = bus.in_valid && (state_q == S_LOAD);
   assign do_write = fire && legal;
   assign bad_hit  = fire && !legal;
   assign cnt_nxt  = cnt_q + 1'b1;
   // last word the memory can hold arrived without the program ending
   assign ovf      = do_write && (cnt_nxt == FULL_CNT) && !f.last;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_LOAD;
         S_LOAD: if (fire && (f.last || ovf)) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Pointer, count and error tracking
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else if ((state_q == S_IDLE) && start) begin
         ptr_q      <= base_addr;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else if (do_write) begin
         ptr_q <= ptr_q + 1'b1;
         cnt_q <= cnt_nxt;
         if (ovf && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= ptr_q;
         end
      end else if (bad_hit && !err_q) begin
         // rejected bundle: the address it would have taken is reported
         err_q      <= 1'b1;
         err_addr_q <= ptr_q;
      end
   end

   // ------------------------------------------------------------------
   // Registered memory write port: accepted at edge k, visible in k+1
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= do_write;
         if (do_write) begin
            wr_addr_q <= ptr_q;
            wr_data_q <= enc_word;
         end
      end
   end

   assign bus.in_ready = (state_q == S_LOAD);
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign count        = cnt_q;
   assign err          = err_q;
   assign err_addr     = err_addr_q;

endmodule
